// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/valid handshake, stalls the
// front end while an access is outstanding, forwards load data into stores and owns MEM/WB.
module mem_stage #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_write,
    input  logic              dm_write,
    input  logic              memtoreg,
    input  logic [15:0]       result,
    input  logic [15:0]       rf_data_out2,
    input  logic [3:0]        rf_read_reg2,
    input  logic [3:0]        rf_write_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic              stall,
    output logic              rf_write_out,
    output logic              memtoreg_out,
    output logic [3:0]        rf_write_reg_out,
    output logic [15:0]       result_out,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       wb_data
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        mem_op, fwd, capture_alu, capture_mem;
    logic [15:0] st_data;

    // Instruction fields held across the access so EX/MEM can change underneath us
    logic        lat_rf_write_q, lat_memtoreg_q;
    logic [3:0]  lat_dest_q;
    logic [15:0] lat_result_q;

    logic        rf_write_out_q, memtoreg_out_q;
    logic [3:0]  rf_write_reg_out_q;
    logic [15:0] result_out_q, mem_data_out_q;

    assign mem_op  = memtoreg | dm_write;
    assign fwd     = dm_write & rf_write_out_q & memtoreg_out_q &
                     (rf_write_reg_out_q == rf_read_reg2) & (rf_read_reg2 != 4'd0);
    assign st_data = fwd ? mem_data_out_q : rf_data_out2;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_op)    state_d = S_WAIT;
            S_WAIT:  if (mem_valid) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        stall       = 1'b0;
        capture_alu = 1'b0;
        capture_mem = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        mem_req   = 1'b1;
                        mem_we    = dm_write;
                        mem_addr  = ADDR_W'(result);
                        mem_wdata = st_data;
                        stall     = 1'b1;
                    end else begin
                        capture_alu = 1'b1;
                    end
                end
                S_WAIT: begin
                    stall       = ~mem_valid;
                    capture_mem = mem_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rf_write_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_dest_q     <= '0;
            lat_result_q   <= '0;
        end else if (mem_req) begin
            lat_rf_write_q <= rf_write;
            lat_memtoreg_q <= memtoreg;
            lat_dest_q     <= rf_write_reg;
            lat_result_q   <= result;
        end
    end

    // MEM/WB: pass-through for ALU ops, completed access on mem_valid, bubble otherwise
    always_ff @(posedge clk) begin
        if (rst || !(capture_alu || capture_mem)) begin
            rf_write_out_q     <= 1'b0;
            memtoreg_out_q     <= 1'b0;
            rf_write_reg_out_q <= '0;
            result_out_q       <= '0;
            mem_data_out_q     <= '0;
        end else if (capture_alu) begin
            rf_write_out_q     <= rf_write;
            memtoreg_out_q     <= memtoreg;
            rf_write_reg_out_q <= rf_write_reg;
            result_out_q       <= result;
            mem_data_out_q     <= '0;
        end else begin
            rf_write_out_q     <= lat_rf_write_q;
            memtoreg_out_q     <= lat_memtoreg_q;
            rf_write_reg_out_q <= lat_dest_q;
            result_out_q       <= lat_result_q;
            mem_data_out_q     <= lat_memtoreg_q ? mem_rdata : 16'h0000;
        end
    end

    assign rf_write_out     = rf_write_out_q;
    assign memtoreg_out     = memtoreg_out_q;
    assign rf_write_reg_out = rf_write_reg_out_q;
    assign result_out       = result_out_q;
    assign mem_data_out     = mem_data_out_q;
    assign wb_data          = memtoreg_out_q ? mem_data_out_q : result_out_q;

endmodule
